cm0_dap_cdc_mask_ctrl: RTL and testbench

Sequencing controller for the DAP's glitch-free AND-mask CDC crossings. It captures a payload into a launch register and holds it stable for a programmable settle time. It then opens the mask (MASKn) and raises REQ, and completes a four-phase REQ/ACK handshake with the far clock domain. It sits on the debug-port side of each DP-to-AP crossing, directly driving the MASKn input of the mask cells on the payload bits.

---
 rtl/cm0_dap_cdc_mask_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cm0_dap_cdc_mask_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cm0_dap_cdc_mask_ctrl.sv
// Launch-register / MASKn / four-phase REQ-ACK sequencer for the DAP's AND-mask CDC crossings.
// Optional ACK timeout with a sticky ERR flag is compiled in with CM0_DAP_CDC_TIMEOUT_EN.
module cm0_dap_cdc_mask_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             SWCLKTCK,
    input  logic             DPRESETn,
    input  logic             START,
    input  logic [WIDTH-1:0] DATAIN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [WIDTH-1:0] DATAOUT,
    output logic             MASKn,
    output logic             REQ,
    input  logic             ACKASYNC
);

    typedef enum logic [1:0] {StIdle, StSettle, StReq, StWaitLo} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             settle_q, settle_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   accept;
    logic                   timeout_hit;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mask_q, mask_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;

    always_ff @(posedge SWCLKTCK or negedge DPRESETn) begin
        if (!DPRESETn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ACKASYNC};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // The DONE cycle still belongs to the finishing transfer, so START is not taken then.
    assign accept = (state_q == StIdle) && START && !done_q;

`ifdef CM0_DAP_CDC_TIMEOUT_EN
    logic [9:0] to_cnt_q;
    logic       cnt_hit;
    logic       err_q, err_d;

    assign cnt_hit     = (to_cnt_q == 10'(TIMEOUT - 1));
    assign timeout_hit = cnt_hit && (((state_q == StReq) && !ack_s) ||
                                     ((state_q == StWaitLo) && ack_s));

    always_ff @(posedge SWCLKTCK or negedge DPRESETn) begin
        if (!DPRESETn) begin
            to_cnt_q <= '0;
        end else if (state_d != state_q) begin
            to_cnt_q <= '0;
        end else if ((state_q == StReq) || (state_q == StWaitLo)) begin
            to_cnt_q <= to_cnt_q + 10'd1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge SWCLKTCK or negedge DPRESETn) begin
        if (!DPRESETn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign timeout_hit = 1'b0;
    assign ERR         = 1'b0;
`endif

    // State register
    always_ff @(posedge SWCLKTCK or negedge DPRESETn) begin
        if (!DPRESETn) begin
            state_q  <= StIdle;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (SETTLE == 0) begin
                        state_d = StReq;
                    end else begin
                        state_d  = StSettle;
                        settle_d = 4'(SETTLE - 1);
                    end
                end
            end
            StSettle: begin
                if (settle_q == 4'd0) begin
                    state_d = StReq;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StReq: begin
                if (ack_s || timeout_hit) begin
                    state_d = StWaitLo;
                end
            end
            StWaitLo: begin
                if (!ack_s || timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output next values; every output is taken from a flop below.
    always_comb begin
        data_d = accept ? DATAIN : data_q;
        mask_d = (state_d == StReq);
        req_d  = (state_d == StReq);
        busy_d = (state_d != StIdle);
        done_d = (state_q == StWaitLo) && (state_d == StIdle) && !timeout_hit;
    end

    always_ff @(posedge SWCLKTCK or negedge DPRESETn) begin
        if (!DPRESETn) begin
            data_q <= '0;
            mask_q <= 1'b0;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            req_q  <= req_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign DATAOUT = data_q;
    assign MASKn   = mask_q;
    assign REQ     = req_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_cm0_dap_cdc_mask_ctrl.sv
// Self-checking bench for cm0_dap_cdc_mask_ctrl: closed-form timing model plus directed corner cases.
module tb_cm0_dap_cdc_mask_ctrl;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int N  = 2;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         ackasync = 1'b0;
    logic [W-1:0] datain = '0;
    logic         busy, done, err, maskn, req;
    logic [W-1:0] dataout;

    logic         start0 = 1'b0;
    logic [W-1:0] data0 = '0;
    logic         busy0, done0, err0, mask0, req0, ack0;
    logic [W-1:0] dout0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model / stimulus state
    bit           model_on = 0;
    bit           active = 0;
    int           a_edge = 0;
    int           d_cur = 3;
    int           next_delay = 3;
    logic [W-1:0] payload = '0;
    bit           start_in = 0;
    logic [W-1:0] data_in = '0;
    bit           ack_forced = 0;
    bit           ack_force_val = 0;
    logic [7:0]   hist = '0;
    logic [W-1:0] early_data;

    cm0_dap_cdc_mask_ctrl #(
        .WIDTH(W), .SETTLE(S), .SYNC_STAGES(N), .TIMEOUT(TO)
    ) dut (
        .SWCLKTCK(clk), .DPRESETn(rst_n), .START(start), .DATAIN(datain),
        .BUSY(busy), .DONE(done), .ERR(err), .DATAOUT(dataout),
        .MASKn(maskn), .REQ(req), .ACKASYNC(ackasync)
    );

    // Second instance with no settle time; its far side echoes REQ immediately.
    cm0_dap_cdc_mask_ctrl #(
        .WIDTH(W), .SETTLE(0), .SYNC_STAGES(N), .TIMEOUT(TO)
    ) dut0 (
        .SWCLKTCK(clk), .DPRESETn(rst_n), .START(start0), .DATAIN(data0),
        .BUSY(busy0), .DONE(done0), .ERR(err0), .DATAOUT(dout0),
        .MASKn(mask0), .REQ(req0), .ACKASYNC(ack0)
    );

    assign ack0 = req0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One cycle: at the falling edge compare against the model, then drive far side and inputs.
    task automatic step();
        int rel, lat;
        bit e_busy, e_done, e_mask;
        @(negedge clk);
        if (model_on) begin
            e_busy = 0; e_done = 0; e_mask = 0;
            lat = S + 2 * (N + 1 + d_cur);
            if (active) begin
                rel    = cyc - a_edge;
                e_busy = (rel < lat);
                e_done = (rel == lat);
                e_mask = (rel >= S) && (rel < S + N + 1 + d_cur);
            end
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("maskn", maskn, e_mask);
            chk("req", req, e_mask);
            chk("dataout", dataout, payload);
            chk("err", err, 0);
        end
        hist     = {hist[6:0], req};
        ackasync = ack_forced ? ack_force_val : hist[d_cur];
        start    = start_in;
        datain   = data_in;
        if (model_on && start_in &&
            (!active || (cyc - a_edge) >= S + 2 * (N + 1 + d_cur) + 1)) begin
            active  = 1;
            a_edge  = cyc + 1;
            payload = data_in;
            d_cur   = next_delay;
        end
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_dataout", dataout, 0);
        chk("rst_maskn", maskn, 0);
        chk("rst_req", req, 0);
        rst_n    = 1'b1;
        model_on = 1;
        repeat (3) step();

        // Basic transfer, far side echoes with 3 cycles delay
        next_delay = 3;
        data_in    = 32'hA5A5_0F0F;
        start_in   = 1;
        step();
        start_in = 0;
        repeat (20) step();

        // Stability: START held high, fixed then changing payload
        data_in  = 32'h1234_5678;
        start_in = 1;
        repeat (60) step();
        repeat (60) begin
            data_in = $urandom;
            step();
        end
        start_in = 0;
        repeat (20) step();

        // Randomized traffic with random far-side delay
        repeat (300) begin
            start_in   = ($urandom_range(0, 2) == 0);
            data_in    = $urandom;
            next_delay = $urandom_range(0, 4);
            step();
        end
        start_in = 0;
        repeat (25) step();

        // Early ACK: ACKASYNC high before START
        model_on      = 0;
        ack_forced    = 1;
        ack_force_val = 1;
        repeat (4) step();
        chk("early_idle_busy", busy, 0);
        chk("early_idle_req", req, 0);
        early_data = $urandom;
        data_in    = early_data;
        start_in   = 1;
        step();
        start_in = 0;
        step();
        chk("early_busy", busy, 1);
        chk("early_dataout", dataout, early_data);
        chk("early_req_r0", req, 0);
        step();
        chk("early_req_r1", req, 0);
        step();
        chk("early_req_rise", req, 1);
        chk("early_mask_rise", maskn, 1);
        step();
        chk("early_req_fall", req, 0);
        chk("early_mask_fall", maskn, 0);
        chk("early_waitlo_busy", busy, 1);
        repeat (4) begin
            step();
            chk("early_hold_busy", busy, 1);
            chk("early_hold_done", done, 0);
        end
        ack_force_val = 0;
        ackasync      = 0;
        step();
        chk("early_done_r1", done, 0);
        step();
        chk("early_done_r2", done, 0);
        step();
        chk("early_done", done, 1);
        chk("early_done_busy", busy, 0);
        step();
        chk("early_done_single", done, 0);
        ack_forced = 0;
        active     = 0;
        payload    = early_data;
        model_on   = 1;
        repeat (3) step();

        // SETTLE=0 instance: MASKn/REQ rise with the DATAOUT load
        data0  = $urandom;
        start0 = 1;
        step();
        start0 = 0;
        chk("s0_dataout", dout0, data0);
        chk("s0_maskn", mask0, 1);
        chk("s0_req", req0, 1);
        chk("s0_busy", busy0, 1);
        for (int r = 1; r <= 6; r++) begin
            step();
            chk("s0_done", done0, (r == 6));
            chk("s0_busy_tail", busy0, (r < 6));
        end
        chk("s0_err", err0, 0);

        // Reset while MASKn is high
        next_delay = 4;
        data_in    = $urandom;
        start_in   = 1;
        step();
        start_in = 0;
        repeat (S + 1) step();
        chk("mid_maskn_high", maskn, 1);
        model_on = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_maskn", maskn, 0);
        chk("mid_rst_req", req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dataout", dataout, 0);
        chk("mid_rst_done", done, 0);
        hist     = '0;
        ackasync = 0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_hold_done", done, 0);
        end
        rst_n    = 1'b1;
        active   = 0;
        payload  = '0;
        model_on = 1;
        repeat (6) step();

`ifdef CM0_DAP_CDC_TIMEOUT_EN
        // ACK stuck low: REQ times out after TO cycles
        model_on      = 0;
        ack_forced    = 1;
        ack_force_val = 0;
        step();
        data_in  = $urandom;
        start_in = 1;
        step();
        start_in = 0;
        repeat (S + 1) step();
        chk("to_req_rise", req, 1);
        for (int i = 1; i <= TO; i++) begin
            step();
            chk("to_req", req, (i < TO));
            chk("to_err", err, (i >= TO));
        end
        chk("to_maskn", maskn, 0);
        chk("to_busy", busy, 1);
        step();
        chk("to_done", done, 1);
        chk("to_done_busy", busy, 0);
        chk("to_done_err", err, 1);
        step();
        chk("to_done_single", done, 0);
        chk("to_err_sticky", err, 1);
        start_in = 1;
        step();
        start_in = 0;
        step();
        chk("to_err_cleared", err, 0);
        chk("to_restart_busy", busy, 1);
        repeat (25) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
